// File: rtl/wifi_viterbi_pkg.sv
// Shared constants, FSM state type and helper functions for the K=7 rate-1/2 Viterbi decoder.
package wifi_viterbi_pkg;

    localparam int unsigned K       = 7;
    localparam int unsigned NSTATES = 1 << (K - 1);
    localparam logic [6:0]  G0      = 7'o133;
    localparam logic [6:0]  G1      = 7'o171;

    typedef enum logic [1:0] {
        StActive,
        StFlush,
        StDone
    } dec_state_e;

    // Encoder output {A,B} when bit u enters with register contents state = {d1..d6}.
    function automatic logic [1:0] expected_ab(input logic [5:0] state, input logic u);
        logic [6:0] sr;
        sr = {u, state};
        return {^(sr & G0), ^(sr & G1)};
    endfunction

    // Hamming weight of a 2-bit vector.
    function automatic logic [1:0] hamming2(input logic [1:0] x);
        return {x[1] & x[0], x[1] ^ x[0]};
    endfunction

    // Modulo less-than on w-bit metrics: sign of (a - b) taken at bit w-1.
    function automatic logic pm_lt(input logic [31:0] a, input logic [31:0] b,
                                   input int unsigned w);
        logic [31:0] diff;
        diff = (a - b) << (32 - w);
        return diff[31];
    endfunction

endpackage

// File: rtl/wifi_viterbi_acs.sv
// Add-compare-select for one trellis state plus its register-exchange survivor.
module wifi_viterbi_acs
    import wifi_viterbi_pkg::*;
#(
    parameter int unsigned StateIdx = 0,
    parameter int unsigned TB_DEPTH = 36,
    parameter int unsigned PM_W     = 8,
    parameter int unsigned INIT_PM  = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                acc_i,
    input  logic                init_i,
    input  logic [1:0]          sym_i,
    input  logic [PM_W-1:0]     pm_a_i,
    input  logic [PM_W-1:0]     pm_b_i,
    input  logic [TB_DEPTH-2:0] surv_a_i,
    input  logic [TB_DEPTH-2:0] surv_b_i,
    output logic [PM_W-1:0]     pm_o,
    output logic [TB_DEPTH-1:0] surv_o
);

    localparam logic [5:0]      State   = 6'(StateIdx);
    localparam logic            U       = State[5];
    // Predecessor a has lsb 0, predecessor b has lsb 1.
    localparam logic [1:0]      ExpA    = expected_ab({State[4:0], 1'b0}, U);
    localparam logic [1:0]      ExpB    = expected_ab({State[4:0], 1'b1}, U);
    localparam logic [PM_W-1:0] ResetPm = (StateIdx == 0) ? '0 : PM_W'(INIT_PM);

    logic [PM_W-1:0]     pm_q, pm_d;
    logic [TB_DEPTH-1:0] surv_q, surv_d;
    logic [PM_W-1:0]     sum_a, sum_b;
    logic                take_b;

    // Branch metrics, modulo compare (tie keeps predecessor a) and survivor extension.
    always_comb begin
        sum_a  = pm_a_i + PM_W'(hamming2(sym_i ^ ExpA));
        sum_b  = pm_b_i + PM_W'(hamming2(sym_i ^ ExpB));
        take_b = pm_lt(32'(sum_b), 32'(sum_a), PM_W);
        pm_d   = pm_q;
        surv_d = surv_q;
        if (init_i) begin
            pm_d   = ResetPm;
            surv_d = '0;
        end else if (acc_i) begin
            pm_d   = take_b ? sum_b : sum_a;
            surv_d = {(take_b ? surv_b_i : surv_a_i), U};
        end
    end

    // Metric and survivor state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pm_q   <= ResetPm;
            surv_q <= '0;
        end else begin
            pm_q   <= pm_d;
            surv_q <= surv_d;
        end
    end

    assign pm_o   = pm_q;
    assign surv_o = surv_q;

endmodule

// File: rtl/wifi_rx_viterbi_decoder.sv
// Hard-decision 64-state Viterbi decoder with register-exchange survivors and frame-end flush.
module wifi_rx_viterbi_decoder
    import wifi_viterbi_pkg::*;
#(
    parameter int unsigned TB_DEPTH = 36,
    parameter int unsigned PM_W     = 8,
    parameter int unsigned INIT_PM  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_in,
    input  logic [1:0] data_in,
    input  logic       last_in,
    output logic       ready,
    output logic       valid_out,
    output logic       data_out,
    output logic       finished
);

    localparam int unsigned       FILL_W  = $clog2(TB_DEPTH + 1);
    localparam int unsigned       IDX_W   = $clog2(TB_DEPTH);
    localparam logic [FILL_W-1:0] FillMax = FILL_W'(TB_DEPTH);

    logic [PM_W-1:0]     pm   [NSTATES];
    logic [TB_DEPTH-1:0] surv [NSTATES];

    dec_state_e        state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              ready_q, ready_d;
    logic              valid_out_q, valid_out_d;
    logic              data_out_q, data_out_d;
    logic              finished_q, finished_d;
    logic              accept, init;
    logic [5:0]        best;

    assign accept = valid_in & ready_q;
    assign init   = (state_q == StDone);

    for (genvar t = 0; t < NSTATES; t++) begin : g_acs
        localparam int unsigned PredA = (t % (NSTATES / 2)) * 2;
        wifi_viterbi_acs #(
            .StateIdx (t),
            .TB_DEPTH (TB_DEPTH),
            .PM_W     (PM_W),
            .INIT_PM  (INIT_PM)
        ) u_acs (
            .clk      (clk),
            .reset    (reset),
            .acc_i    (accept),
            .init_i   (init),
            .sym_i    (data_in),
            .pm_a_i   (pm[PredA]),
            .pm_b_i   (pm[PredA + 1]),
            .surv_a_i (surv[PredA][TB_DEPTH-2:0]),
            .surv_b_i (surv[PredA + 1][TB_DEPTH-2:0]),
            .pm_o     (pm[t]),
            .surv_o   (surv[t])
        );
    end

    // Best-state search: pairwise modulo-min tree, the left (lower index) side wins ties.
    always_comb begin
        logic [5:0] cand [NSTATES];
        for (int i = 0; i < NSTATES; i++) begin
            cand[i] = 6'(i);
        end
        for (int w = NSTATES / 2; w >= 1; w = w / 2) begin
            for (int i = 0; i < w; i++) begin
                if (pm_lt(32'(pm[cand[2*i+1]]), 32'(pm[cand[2*i]]), PM_W)) begin
                    cand[i] = cand[2*i+1];
                end else begin
                    cand[i] = cand[2*i];
                end
            end
        end
        best = cand[0];
    end

    // Frame control: output during decode, drain the state-0 survivor, then reinitialise.
    always_comb begin
        fill_inc    = (fill_q == FillMax) ? fill_q : fill_q + 1'b1;
        state_d     = state_q;
        fill_d      = fill_q;
        idx_d       = idx_q;
        valid_out_d = 1'b0;
        data_out_d  = data_out_q;
        finished_d  = 1'b0;
        unique case (state_q)
            StActive: begin
                if (accept) begin
                    fill_d = fill_inc;
                    if (fill_q == FillMax) begin
                        valid_out_d = 1'b1;
                        data_out_d  = surv[best][TB_DEPTH-1];
                    end
                    if (last_in) begin
                        state_d = StFlush;
                        // Short frames only hold fill_inc meaningful bits.
                        idx_d   = IDX_W'(fill_inc - 1'b1);
                    end
                end
            end
            StFlush: begin
                valid_out_d = 1'b1;
                data_out_d  = surv[0][idx_q];
                if (idx_q == '0) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            StDone: begin
                finished_d = 1'b1;
                fill_d     = '0;
                state_d    = StActive;
            end
            default: state_d = StActive;
        endcase
        ready_d = (state_d == StActive);
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StActive;
            fill_q      <= '0;
            idx_q       <= '0;
            ready_q     <= 1'b1;
            valid_out_q <= 1'b0;
            data_out_q  <= 1'b0;
            finished_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            idx_q       <= idx_d;
            ready_q     <= ready_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            finished_q  <= finished_d;
        end
    end

    assign ready     = ready_q;
    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign finished  = finished_q;

endmodule
